// File: rtl/rob_queue_if.sv
// Dispatch / execute / writeback bundle for the reorder buffer.
interface rob_queue_if #(
    parameter int unsigned DATAW       = 32,
    parameter int unsigned FLAGSW      = 4,
    parameter int unsigned TAGW        = 6,
    parameter int unsigned LOG2ENTRIES = 4,
    parameter int unsigned DESTW       = 5
);
    // dispatch
    logic                   alloc_en;
    logic [DESTW-1:0]       alloc_dest;
    logic                   alloc_ready;
    logic [TAGW-1:0]        alloc_tag;

    // execution results
    logic                   complete_en;
    logic [TAGW-1:0]        complete_tag;
    logic [DATAW-1:0]       complete_value;
    logic [FLAGSW-1:0]      complete_flags;

    // result broadcast to reservation stations
    logic                   broadcast_en;
    logic [TAGW-1:0]        broadcast_tag;
    logic [DATAW-1:0]       broadcast_value;
    logic [FLAGSW-1:0]      broadcast_flags;

    // in-order retirement
    logic                   retire_valid;
    logic [DESTW-1:0]       retire_dest;
    logic [TAGW-1:0]        retire_tag;
    logic [DATAW-1:0]       retire_value;
    logic [FLAGSW-1:0]      retire_flags;
    logic                   retire_accept;

    // control / status
    logic                   flush;
    logic                   empty;
    logic [LOG2ENTRIES:0]   count;

    // pipeline side that drives requests into the ROB
    modport master (
        output alloc_en, alloc_dest,
        output complete_en, complete_tag, complete_value, complete_flags,
        output retire_accept, flush,
        input  alloc_ready, alloc_tag,
        input  broadcast_en, broadcast_tag, broadcast_value, broadcast_flags,
        input  retire_valid, retire_dest, retire_tag, retire_value, retire_flags,
        input  empty, count
    );

    // the ROB itself
    modport slave (
        input  alloc_en, alloc_dest,
        input  complete_en, complete_tag, complete_value, complete_flags,
        input  retire_accept, flush,
        output alloc_ready, alloc_tag,
        output broadcast_en, broadcast_tag, broadcast_value, broadcast_flags,
        output retire_valid, retire_dest, retire_tag, retire_value, retire_flags,
        output empty, count
    );
endinterface

// File: rtl/rob_queue.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order retire.
module rob_queue #(
    parameter int unsigned DATAW       = 32,
    parameter int unsigned FLAGSW      = 4,
    parameter int unsigned TAGW        = 6,
    parameter int unsigned LOG2ENTRIES = 4,
    parameter int unsigned DESTW       = 5
) (
    input  logic          clk,
    input  logic          rst,
    rob_queue_if.slave    bus
);
    localparam int unsigned ENTRIES = 1 << LOG2ENTRIES;
    localparam int unsigned IDXW    = LOG2ENTRIES;
    localparam int unsigned PTRW    = LOG2ENTRIES + 1;

    // pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PTRW-1:0]    head;
    logic [PTRW-1:0]    tail;
    logic [IDXW-1:0]    head_idx;
    logic [IDXW-1:0]    tail_idx;
    logic [IDXW-1:0]    cmp_idx;

    // per-entry status and payload
    logic [ENTRIES-1:0] allocated;
    logic [ENTRIES-1:0] done;
    logic [DESTW-1:0]   dest_mem  [ENTRIES];
    logic [DATAW-1:0]   value_mem [ENTRIES];
    logic [FLAGSW-1:0]  flags_mem [ENTRIES];

    // registered broadcast
    logic               bcast_en;
    logic [TAGW-1:0]    bcast_tag;
    logic [DATAW-1:0]   bcast_value;
    logic [FLAGSW-1:0]  bcast_flags;

    // decoded events for this cycle
    logic [PTRW-1:0]    count_c;
    logic               full_c;
    logic               empty_c;
    logic               tag_in_range_c;
    logic               complete_hit_c;
    logic               retire_valid_c;
    logic               do_alloc_c;
    logic               do_retire_c;

    assign head_idx = head[IDXW-1:0];
    assign tail_idx = tail[IDXW-1:0];
    assign cmp_idx  = bus.complete_tag[IDXW-1:0];

    // occupancy and event decode, all from registered state plus this cycle's requests
    always_comb begin
        count_c        = tail - head;
        full_c         = (count_c == PTRW'(ENTRIES));
        empty_c        = (count_c == '0);
        // tags with bits above the index range never name a real entry
        tag_in_range_c = ((bus.complete_tag >> IDXW) == '0);
        complete_hit_c = bus.complete_en & tag_in_range_c
                       & allocated[cmp_idx] & ~done[cmp_idx];
        retire_valid_c = ~empty_c & done[head_idx];
        // fullness is judged before any same-cycle retire frees a slot
        do_alloc_c     = bus.alloc_en & ~full_c;
        do_retire_c    = retire_valid_c & bus.retire_accept;
    end

    // head/tail pointers; reset and flush both rewind to zero
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (do_alloc_c) begin
                tail <= tail + PTRW'(1);
            end
            if (do_retire_c) begin
                head <= head + PTRW'(1);
            end
        end
    end

    // allocated/done bits; flush leaves stale done bits, which a new alloc clears
    always_ff @(posedge clk) begin
        if (rst) begin
            allocated <= '0;
            done      <= '0;
        end else if (bus.flush) begin
            allocated <= '0;
        end else begin
            // alloc, complete and retire always hit distinct entries
            if (do_alloc_c) begin
                allocated[tail_idx] <= 1'b1;
                done[tail_idx]      <= 1'b0;
            end
            if (complete_hit_c) begin
                done[cmp_idx] <= 1'b1;
            end
            if (do_retire_c) begin
                allocated[head_idx] <= 1'b0;
            end
        end
    end

    // payload storage; contents only matter while the entry is allocated
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) begin
            if (do_alloc_c) begin
                dest_mem[tail_idx] <= bus.alloc_dest;
            end
            if (complete_hit_c) begin
                value_mem[cmp_idx] <= bus.complete_value;
                flags_mem[cmp_idx] <= bus.complete_flags;
            end
        end
    end

    // one-cycle result broadcast for accepted completions only
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_en    <= 1'b0;
            bcast_tag   <= '0;
            bcast_value <= '0;
            bcast_flags <= '0;
        end else begin
            bcast_en <= complete_hit_c & ~bus.flush;
            if (complete_hit_c && !bus.flush) begin
                bcast_tag   <= bus.complete_tag;
                bcast_value <= bus.complete_value;
                bcast_flags <= bus.complete_flags;
            end
        end
    end

    // status and head-entry view
    always_comb begin
        bus.alloc_ready     = ~full_c;
        bus.alloc_tag       = TAGW'(tail_idx);
        bus.count           = count_c;
        bus.empty           = empty_c;
        bus.retire_valid    = retire_valid_c;
        bus.retire_tag      = TAGW'(head_idx);
        bus.retire_dest     = dest_mem[head_idx];
        bus.retire_value    = value_mem[head_idx];
        bus.retire_flags    = flags_mem[head_idx];
        bus.broadcast_en    = bcast_en;
        bus.broadcast_tag   = bcast_tag;
        bus.broadcast_value = bcast_value;
        bus.broadcast_flags = bcast_flags;
    end
endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue: vector table plus fill/wrap, flush and reset sequences.
module tb_rob_queue;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rob_queue_if bus ();

    rob_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        ae;
        logic [4:0]  ad;
        logic        ce;
        logic [5:0]  ct;
        logic [31:0] cv;
        logic        ra;
        logic        rdy;
        logic [5:0]  atag;
        logic [4:0]  cnt;
        logic        emp;
        logic        rv;
        logic [5:0]  rtag;
        logic [31:0] rval;
        logic [4:0]  rdst;
        logic        be;
        logic [5:0]  btag;
        logic [31:0] bval;
        logic        cbd;
    } vec_t;

    vec_t vt [14];

    function automatic vec_t v(input int r, input int fl, input int ae, input int ad,
                               input int ce, input int ct, input int cv, input int ra,
                               input int rdy, input int atag, input int cnt, input int emp,
                               input int rv, input int rtag, input int rval, input int rdst,
                               input int be, input int btag, input int bval, input int cbd);
        vec_t x;
        x.rst  = 1'(r);    x.fl   = 1'(fl);   x.ae   = 1'(ae);   x.ad   = 5'(ad);
        x.ce   = 1'(ce);   x.ct   = 6'(ct);   x.cv   = 32'(cv);  x.ra   = 1'(ra);
        x.rdy  = 1'(rdy);  x.atag = 6'(atag); x.cnt  = 5'(cnt);  x.emp  = 1'(emp);
        x.rv   = 1'(rv);   x.rtag = 6'(rtag); x.rval = 32'(rval); x.rdst = 5'(rdst);
        x.be   = 1'(be);   x.btag = 6'(btag); x.bval = 32'(bval); x.cbd  = 1'(cbd);
        return x;
    endfunction

    function automatic logic [3:0] flags_of(input logic [31:0] val);
        return val[3:0] ^ 4'h5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int r, input int fl, input int ae, input int ad,
                         input int ce, input int ct, input int cv, input int ra);
        logic [31:0] val;
        val                = 32'(cv);
        rst                = 1'(r);
        bus.flush          = 1'(fl);
        bus.alloc_en       = 1'(ae);
        bus.alloc_dest     = 5'(ad);
        bus.complete_en    = 1'(ce);
        bus.complete_tag   = 6'(ct);
        bus.complete_value = val;
        bus.complete_flags = flags_of(val);
        bus.retire_accept  = 1'(ra);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle();
        rst = 1'b1;

        // rst, fl, ae, ad, ce, ct, cv, ra | rdy, atag, cnt, emp, rv, rtag, rval, rdst, be, btag, bval, cbd
        vt[0]  = v(1, 0, 0, 0, 0, 0, 0,     0,  1, 0, 0, 1,  0, 0, 0,     0,  0, 0, 0,     1);
        vt[1]  = v(0, 0, 1, 1, 0, 0, 0,     0,  1, 1, 1, 0,  0, 0, 0,     0,  0, 0, 0,     0);
        vt[2]  = v(0, 0, 1, 2, 0, 0, 0,     0,  1, 2, 2, 0,  0, 0, 0,     0,  0, 0, 0,     0);
        vt[3]  = v(0, 0, 1, 3, 0, 0, 0,     0,  1, 3, 3, 0,  0, 0, 0,     0,  0, 0, 0,     0);
        vt[4]  = v(0, 0, 0, 0, 1, 1, 'hAA,  0,  1, 3, 3, 0,  0, 0, 0,     0,  1, 1, 'hAA,  0);
        vt[5]  = v(0, 0, 0, 0, 1, 3, 'h99,  0,  1, 3, 3, 0,  0, 0, 0,     0,  0, 0, 0,     0);
        vt[6]  = v(0, 0, 0, 0, 1, 1, 'h55,  0,  1, 3, 3, 0,  0, 0, 0,     0,  0, 0, 0,     0);
        vt[7]  = v(0, 0, 0, 0, 1, 0, 'h11,  0,  1, 3, 3, 0,  1, 0, 'h11,  1,  1, 0, 'h11,  0);
        vt[8]  = v(0, 0, 0, 0, 0, 0, 0,     1,  1, 3, 2, 0,  1, 1, 'hAA,  2,  0, 0, 0,     0);
        vt[9]  = v(0, 0, 0, 0, 0, 0, 0,     1,  1, 3, 1, 0,  0, 2, 0,     0,  0, 0, 0,     0);
        vt[10] = v(0, 0, 0, 0, 0, 0, 0,     1,  1, 3, 1, 0,  0, 2, 0,     0,  0, 0, 0,     0);
        vt[11] = v(0, 0, 0, 0, 1, 2, 'h22,  1,  1, 3, 1, 0,  1, 2, 'h22,  3,  1, 2, 'h22,  0);
        vt[12] = v(0, 0, 1, 9, 0, 0, 0,     1,  1, 4, 1, 0,  0, 3, 0,     0,  0, 0, 0,     0);
        vt[13] = v(0, 0, 0, 0, 1, 3, 'h33,  0,  1, 4, 1, 0,  1, 3, 'h33,  9,  1, 3, 'h33,  0);

        for (int i = 0; i < 14; i++) begin
            drive(int'(vt[i].rst), int'(vt[i].fl), int'(vt[i].ae), int'(vt[i].ad),
                  int'(vt[i].ce), int'(vt[i].ct), int'(vt[i].cv), int'(vt[i].ra));
            tick();
            chk($sformatf("v%0d_alloc_ready", i), 64'(bus.alloc_ready), 64'(vt[i].rdy));
            chk($sformatf("v%0d_alloc_tag", i), 64'(bus.alloc_tag), 64'(vt[i].atag));
            chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(vt[i].cnt));
            chk($sformatf("v%0d_empty", i), 64'(bus.empty), 64'(vt[i].emp));
            chk($sformatf("v%0d_retire_valid", i), 64'(bus.retire_valid), 64'(vt[i].rv));
            chk($sformatf("v%0d_retire_tag", i), 64'(bus.retire_tag), 64'(vt[i].rtag));
            if (vt[i].rv) begin
                chk($sformatf("v%0d_retire_value", i), 64'(bus.retire_value), 64'(vt[i].rval));
                chk($sformatf("v%0d_retire_flags", i), 64'(bus.retire_flags), 64'(flags_of(vt[i].rval)));
                chk($sformatf("v%0d_retire_dest", i), 64'(bus.retire_dest), 64'(vt[i].rdst));
            end
            chk($sformatf("v%0d_broadcast_en", i), 64'(bus.broadcast_en), 64'(vt[i].be));
            if (vt[i].be) begin
                chk($sformatf("v%0d_broadcast_tag", i), 64'(bus.broadcast_tag), 64'(vt[i].btag));
                chk($sformatf("v%0d_broadcast_value", i), 64'(bus.broadcast_value), 64'(vt[i].bval));
                chk($sformatf("v%0d_broadcast_flags", i), 64'(bus.broadcast_flags), 64'(flags_of(vt[i].bval)));
            end else if (vt[i].cbd) begin
                chk($sformatf("v%0d_broadcast_tag", i), 64'(bus.broadcast_tag), 64'(vt[i].btag));
                chk($sformatf("v%0d_broadcast_value", i), 64'(bus.broadcast_value), 64'(vt[i].bval));
                chk($sformatf("v%0d_broadcast_flags", i), 64'(bus.broadcast_flags), 64'(0));
            end
        end

        // fill to capacity, then an ignored 17th alloc
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill_tag%0d", i), 64'(bus.alloc_tag), 64'(i));
            drive(0, 0, 1, i, 0, 0, 0, 0);
            tick();
        end
        chk("fill_count", 64'(bus.count), 64'(16));
        chk("fill_ready", 64'(bus.alloc_ready), 64'(0));
        drive(0, 0, 1, 7, 0, 0, 0, 0);
        tick();
        chk("over_count", 64'(bus.count), 64'(16));
        chk("over_tag", 64'(bus.alloc_tag), 64'(0));
        chk("over_ready", 64'(bus.alloc_ready), 64'(0));

        // full with head done: same-cycle alloc and retire retires only
        drive(0, 0, 0, 0, 1, 0, 'h77, 0);
        tick();
        chk("full_head_rv", 64'(bus.retire_valid), 64'(1));
        chk("full_head_dest", 64'(bus.retire_dest), 64'(0));
        drive(0, 0, 1, 'h1F, 0, 0, 0, 1);
        tick();
        chk("full_ret_count", 64'(bus.count), 64'(15));
        chk("full_ret_ready", 64'(bus.alloc_ready), 64'(1));
        chk("full_ret_atag", 64'(bus.alloc_tag), 64'(0));
        chk("full_ret_rtag", 64'(bus.retire_tag), 64'(1));
        chk("full_ret_rv", 64'(bus.retire_valid), 64'(0));
        drive(0, 0, 1, 'h1E, 0, 0, 0, 0);
        tick();
        chk("wrap_count", 64'(bus.count), 64'(16));
        chk("wrap_ready", 64'(bus.alloc_ready), 64'(0));
        chk("wrap_atag", 64'(bus.alloc_tag), 64'(1));
        // reused slot 0 must have come back not-done
        drive(0, 0, 0, 0, 1, 0, 'h66, 0);
        tick();
        chk("wrap_bcast_en", 64'(bus.broadcast_en), 64'(1));
        chk("wrap_bcast_tag", 64'(bus.broadcast_tag), 64'(0));
        chk("wrap_bcast_value", 64'(bus.broadcast_value), 64'(32'h66));
        chk("wrap_rv", 64'(bus.retire_valid), 64'(0));

        // reset beats flush, alloc, complete and retire on a full queue
        drive(1, 1, 1, 3, 1, 5, 'hDEAD, 1);
        tick();
        idle();
        chk("rst_count", 64'(bus.count), 64'(0));
        chk("rst_empty", 64'(bus.empty), 64'(1));
        chk("rst_ready", 64'(bus.alloc_ready), 64'(1));
        chk("rst_atag", 64'(bus.alloc_tag), 64'(0));
        chk("rst_rv", 64'(bus.retire_valid), 64'(0));
        chk("rst_bcast_en", 64'(bus.broadcast_en), 64'(0));
        chk("rst_bcast_tag", 64'(bus.broadcast_tag), 64'(0));
        chk("rst_bcast_value", 64'(bus.broadcast_value), 64'(0));
        chk("rst_bcast_flags", 64'(bus.broadcast_flags), 64'(0));

        // flush with 5 in flight plus a same-cycle completion
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, i + 10, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0, 'h44, 0);
        tick();
        chk("pre_flush_count", 64'(bus.count), 64'(5));
        chk("pre_flush_rv", 64'(bus.retire_valid), 64'(1));
        drive(0, 1, 1, 7, 1, 2, 'h5A, 1);
        tick();
        idle();
        chk("flush_empty", 64'(bus.empty), 64'(1));
        chk("flush_count", 64'(bus.count), 64'(0));
        chk("flush_bcast_en", 64'(bus.broadcast_en), 64'(0));
        chk("flush_ready", 64'(bus.alloc_ready), 64'(1));
        chk("flush_atag", 64'(bus.alloc_tag), 64'(0));
        chk("flush_rv", 64'(bus.retire_valid), 64'(0));
        drive(0, 0, 1, 4, 0, 0, 0, 0);
        tick();
        idle();
        chk("post_flush_count", 64'(bus.count), 64'(1));
        chk("post_flush_rtag", 64'(bus.retire_tag), 64'(0));
        chk("post_flush_rv", 64'(bus.retire_valid), 64'(0));
        chk("post_flush_atag", 64'(bus.alloc_tag), 64'(1));
        tick();
        chk("idle_bcast_en", 64'(bus.broadcast_en), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
